// File: rtl/alu_pkg.sv
// Shared definitions for the divider and the external ALU it drives:
// op codes, flag bit positions, funct encoding and the divider state enum.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;

  typedef enum logic [1:0] {
    FUNCT_DIV  = 2'b00,
    FUNCT_DIVU = 2'b01,
    FUNCT_REM  = 2'b10,
    FUNCT_REMU = 2'b11
  } funct_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_ITER   = 3'd3,
    S_SIGN_Q = 3'd4,
    S_SIGN_R = 3'd5,
    S_DONE   = 3'd6
  } div_state_e;

  function automatic logic isSignedOp(input logic [1:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_REM);
  endfunction

  function automatic logic isRemOp(input logic [1:0] f);
    return (f == FUNCT_REM) || (f == FUNCT_REMU);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring divider that borrows an external combinational ALU for every subtraction.
// Optional macro DIV_EARLY_EXIT_EN: divide-by-zero and signed overflow skip straight to DONE.
module alu_divider
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic [1:0]   funct,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] alu_src1,
  output logic [N-1:0] alu_src2,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_res,
  input  logic [3:0]   alu_flags
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  div_state_e    r_state;
  div_state_e    w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_rem;
  logic [1:0]    r_funct;
  logic          r_negQ;
  logic          r_negR;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic          w_divZero;
  logic [N-1:0]  w_iterSrc1;
  logic          w_take;
  logic          w_unused;

  assign w_accept   = start_valid && (r_state == S_IDLE);
  assign w_divZero  = (divisor == '0);
  assign w_iterSrc1 = {r_rem[N-2:0], r_a[N-1]};
  // The subtraction is taken when the shifted partial remainder is >= divisor:
  // either no borrow, or the bit shifted out of rem made it exceed N bits.
  assign w_take     = r_rem[N-1] | ~alu_flags[FLAG_CARRY];
  assign w_unused   = &{1'b0, alu_flags[FLAG_ZERO], alu_flags[FLAG_NEG], alu_flags[FLAG_OVF]};

`ifdef DIV_EARLY_EXIT_EN
  logic w_special;
  logic w_ovf;
  assign w_ovf     = isSignedOp(funct) && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
  assign w_special = w_divZero || w_ovf;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    result      = '0;
    alu_op      = ALU_ADD;
    alu_src1    = '0;
    alu_src2    = '0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_next = S_ABS_A;
`ifdef DIV_EARLY_EXIT_EN
          if (w_special) w_next = S_DONE;
`endif
        end
      end
      S_ABS_A: begin
        alu_op   = ALU_SUB;
        alu_src2 = r_a;
        w_next   = S_ABS_B;
      end
      S_ABS_B: begin
        alu_op   = ALU_SUB;
        alu_src2 = r_b;
        w_next   = S_ITER;
      end
      S_ITER: begin
        alu_op   = ALU_SUB;
        alu_src1 = w_iterSrc1;
        alu_src2 = r_b;
        if (r_count == CW'(N - 1)) w_next = S_SIGN_Q;
      end
      S_SIGN_Q: begin
        alu_op   = ALU_SUB;
        alu_src2 = r_a;
        w_next   = S_SIGN_R;
      end
      S_SIGN_R: begin
        alu_op   = ALU_SUB;
        alu_src2 = r_rem;
        w_next   = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        result     = isRemOp(r_funct) ? r_rem : r_a;
        if (done_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_a holds the dividend, is shifted out MSB first, and fills with quotient bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_funct <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= dividend;
            r_b     <= divisor;
            r_rem   <= '0;
            r_funct <= funct;
            r_count <= '0;
            // Division by zero keeps an all-ones quotient, so never negate it.
            r_negQ  <= isSignedOp(funct) && (dividend[N-1] ^ divisor[N-1]) && !w_divZero;
            r_negR  <= isSignedOp(funct) && dividend[N-1];
`ifdef DIV_EARLY_EXIT_EN
            if (w_divZero) begin
              r_a   <= '1;
              r_rem <= dividend;
            end else if (w_ovf) begin
              r_a   <= {1'b1, {(N-1){1'b0}}};
              r_rem <= '0;
            end
`endif
          end
        end
        S_ABS_A:  if (r_negR) r_a <= alu_res;
        S_ABS_B:  if (isSignedOp(r_funct) && r_b[N-1]) r_b <= alu_res;
        S_ITER: begin
          r_rem   <= w_take ? alu_res : w_iterSrc1;
          r_a     <= {r_a[N-2:0], w_take};
          r_count <= r_count + 1'b1;
        end
        S_SIGN_Q: if (r_negQ) r_a <= alu_res;
        S_SIGN_R: if (r_negR) r_rem <= alu_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider with a behavioural ALU alongside it.
// Expected latency of special cases follows DIV_EARLY_EXIT_EN.
module tb_alu_divider;
  import alu_pkg::*;

  localparam int N = 32;
`ifdef DIV_EARLY_EXIT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 37;
`endif
  localparam int NORMAL_LAT = 37;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [1:0]   funct;
  logic         done_valid;
  logic         done_ready;
  logic [N-1:0] result;
  logic [N-1:0] alu_src1;
  logic [N-1:0] alu_src2;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_res;
  logic [3:0]   alu_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_divider #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor), .funct(funct),
    .done_valid(done_valid), .done_ready(done_ready), .result(result),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_res(alu_res), .alu_flags(alu_flags)
  );

  // Behavioural stand-in for the external ALU; carry flag is borrow on SUB.
  logic [N:0] aluWide;
  always_comb begin
    aluWide = '0;
    if (alu_op == ALU_SUB) aluWide = {1'b0, alu_src1} - {1'b0, alu_src2};
    else                   aluWide = {1'b0, alu_src1} + {1'b0, alu_src2};
    alu_res               = aluWide[N-1:0];
    alu_flags             = '0;
    alu_flags[FLAG_ZERO]  = (aluWide[N-1:0] == '0);
    alu_flags[FLAG_NEG]   = aluWide[N-1];
    alu_flags[FLAG_CARRY] = aluWide[N];
    alu_flags[FLAG_OVF]   = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, measure cycles to done_valid, optionally stall the consumer.
  task automatic applyStimulus(input string tag, input logic [1:0] f, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [N-1:0] expResult,
                               input int expLat, input int hold);
    int lat;
    @(negedge clk);
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    funct       = f;
    done_ready  = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 1;
    if (expLat > 1) checkOutput({tag, "_absa_op"}, {28'd0, alu_op}, {28'd0, ALU_SUB});
    while (!done_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput(tag, result, expResult);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_stall_res"}, result, expResult);
      checkOutput({tag, "_stall_rdy"}, {31'd0, start_ready}, 32'd0);
      checkOutput({tag, "_stall_vld"}, {31'd0, done_valid}, 32'd1);
    end
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    checkOutput({tag, "_idle_rdy"}, {31'd0, start_ready}, 32'd1);
    checkOutput({tag, "_idle_vld"}, {31'd0, done_valid}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    dividend    = '0;
    divisor     = '0;
    funct       = 2'b00;
    done_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_start_ready", {31'd0, start_ready}, 32'd1);
    checkOutput("rst_done_valid", {31'd0, done_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_alu_op", {28'd0, alu_op}, 32'd0);
    checkOutput("rst_alu_src1", alu_src1, 32'd0);
    checkOutput("rst_alu_src2", alu_src2, 32'd0);

    applyStimulus("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT, 0);
    applyStimulus("remu_100_7", FUNCT_REMU, 32'd100, 32'd7, 32'd2, NORMAL_LAT, 0);
    applyStimulus("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT, 0);
    applyStimulus("rem_m7_2", FUNCT_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT, 0);
    applyStimulus("divu_max_1", FUNCT_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_LAT, 0);
    applyStimulus("divu_max_3", FUNCT_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, NORMAL_LAT, 0);
    applyStimulus("remu_big", FUNCT_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, NORMAL_LAT, 0);
    applyStimulus("div_5_0", FUNCT_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
    applyStimulus("rem_5_0", FUNCT_REM, 32'd5, 32'd0, 32'd5, SPECIAL_LAT, 0);
    applyStimulus("rem_m7_0", FUNCT_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPECIAL_LAT, 0);
    applyStimulus("div_m7_0", FUNCT_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
    applyStimulus("divu_5_0", FUNCT_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
    applyStimulus("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, 0);
    applyStimulus("rem_ovf", FUNCT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT, 0);
    applyStimulus("divu_nonovf", FUNCT_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORMAL_LAT, 0);
    applyStimulus("div_m100_7", FUNCT_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NORMAL_LAT, 0);
    applyStimulus("rem_100_m7", FUNCT_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, NORMAL_LAT, 0);
    applyStimulus("stall_div", FUNCT_DIVU, 32'd1000, 32'd10, 32'd100, NORMAL_LAT, 5);

    // Reset in the middle of iteration, then a clean request afterwards.
    @(negedge clk);
    start_valid = 1'b1;
    dividend    = 32'd100;
    divisor     = 32'd7;
    funct       = FUNCT_DIVU;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    checkOutput("midrst_done_valid", {31'd0, done_valid}, 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_alu_op", {28'd0, alu_op}, 32'd0);
    applyStimulus("divu_9_3", FUNCT_DIVU, 32'd9, 32'd3, 32'd3, NORMAL_LAT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
